// File: rtl/alu_sequencer.sv
// alu_sequencer: registered issue stage in front of a combinational ALU,
// followed by an in-order response FIFO. Requests are admitted only while
// there is room for their result, so a capture can never overflow the FIFO.
module alu_sequencer #(
   parameter int N     = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [N-1:0]           req_op_a,
   input  logic [N-1:0]           req_op_b,
   input  logic [1:0]             req_sel,
   input  logic [TAG_W-1:0]       req_tag,
   output logic [N-1:0]           alu_op_a,
   output logic [N-1:0]           alu_op_b,
   output logic [1:0]             alu_sel,
   input  logic [N-1:0]           alu_result,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [N-1:0]           rsp_result,
   output logic [TAG_W-1:0]       rsp_tag,
   output logic                   rsp_zero,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   // issue stage
   logic             issue_vld_q, issue_vld_d;
   logic [N-1:0]     op_a_q, op_a_d;
   logic [N-1:0]     op_b_q, op_b_d;
   logic [1:0]       sel_q, sel_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   // response FIFO
   logic [N-1:0]     res_mem_q [DEPTH];
   logic [TAG_W-1:0] tag_mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [N-1:0]     last_res_q, last_res_d;
   logic [TAG_W-1:0] last_tag_q, last_tag_d;

   logic accept, push, pop;

   // Occupancy counts the issue-stage entry too, so every admitted request
   // already owns a FIFO slot by the time it is captured.
   assign occupancy = count_q + {{AW{1'b0}}, issue_vld_q};
   assign req_ready = !rst && (occupancy < FULL);
   assign accept    = req_valid && req_ready;
   assign push      = issue_vld_q;
   assign pop       = rsp_valid && rsp_ready;

   assign alu_op_a  = op_a_q;
   assign alu_op_b  = op_b_q;
   assign alu_sel   = sel_q;

   // Head of FIFO when non-empty; otherwise the last value that left.
   assign rsp_valid  = (count_q != '0);
   assign rsp_result = rsp_valid ? res_mem_q[rd_ptr_q] : last_res_q;
   assign rsp_tag    = rsp_valid ? tag_mem_q[rd_ptr_q] : last_tag_q;
   assign rsp_zero   = (rsp_result == '0);

   // Issue stage next state: load on accept, otherwise hold operands and drop valid.
   always_comb begin
      issue_vld_d = accept;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      sel_d       = sel_q;
      tag_d       = tag_q;
      if (accept) begin
         op_a_d = req_op_a;
         op_b_d = req_op_b;
         sel_d  = req_sel;
         tag_d  = req_tag;
      end
   end

   // Issue stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_vld_q <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         sel_q       <= '0;
         tag_q       <= '0;
      end else begin
         issue_vld_q <= issue_vld_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         sel_q       <= sel_d;
         tag_q       <= tag_d;
      end
   end

   // FIFO pointer/count next state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      last_res_d = last_res_q;
      last_tag_d = last_tag_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         last_res_d = res_mem_q[rd_ptr_q];
         last_tag_d = tag_mem_q[rd_ptr_q];
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage and control; capture takes the ALU result of the issued op.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_res_q <= '0;
         last_tag_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            res_mem_q[i] <= '0;
            tag_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_res_q <= last_res_d;
         last_tag_q <= last_tag_d;
         if (push) begin
            res_mem_q[wr_ptr_q] <= alu_result;
            tag_mem_q[wr_ptr_q] <= tag_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;
   localparam int N = 32, DEPTH = 4, TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0, req_ready;
   logic [N-1:0]     req_op_a = '0, req_op_b = '0;
   logic [1:0]       req_sel = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic [N-1:0]     alu_op_a, alu_op_b, alu_result;
   logic [1:0]       alu_sel;
   logic             rsp_valid, rsp_ready = 1'b0;
   logic [N-1:0]     rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_zero;
   logic [$clog2(DEPTH):0] occupancy;

   int tests = 0, fails = 0;

   alu_sequencer #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op_a(req_op_a), .req_op_b(req_op_b), .req_sel(req_sel), .req_tag(req_tag),
      .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_sel(alu_sel), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_zero(rsp_zero),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // combinational ALU
   always_comb begin
      case (alu_sel)
         2'b00:   alu_result = alu_op_a + alu_op_b;
         2'b01:   alu_result = alu_op_a - alu_op_b;
         2'b10:   alu_result = alu_op_a & alu_op_b;
         default: alu_result = alu_op_a | alu_op_b;
      endcase
   end

   function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [1:0] s);
      case (s)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] s,
                        input logic [TAG_W-1:0] t);
      req_valid = 1'b1; req_op_a = a; req_op_b = b; req_sel = s; req_tag = t;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
      tests++; if (occupancy !== '0) begin fails++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_rst got=%0h exp=0", req_ready); end
      tests++; if (rsp_result !== '0 || rsp_tag !== '0) begin fails++; $display("FAIL reset_rsp_data got=%0h/%0h exp=0/0", rsp_result, rsp_tag); end
      tests++; if (rsp_zero !== 1'b1) begin fails++; $display("FAIL reset_zero got=%0h exp=1", rsp_zero); end
      tests++; if (alu_op_a !== '0 || alu_op_b !== '0 || alu_sel !== '0) begin fails++; $display("FAIL reset_alu got=%0h/%0h/%0h exp=0/0/0", alu_op_a, alu_op_b, alu_sel); end
      step();
      rst = 1'b0;
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after got=%0h exp=1", req_ready); end
      step();
   endtask

   task automatic test_single();
      drive(32'h5, 32'h3, 2'b00, 4'h1);
      step();                       // accept at edge k
      req_valid = 1'b0;
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid got=%0h exp=0", rsp_valid); end
      tests++; if (alu_op_a !== 32'h5 || alu_op_b !== 32'h3 || alu_sel !== 2'b00) begin fails++; $display("FAIL single_alu_bus got=%0h/%0h/%0h exp=5/3/0", alu_op_a, alu_op_b, alu_sel); end
      step();                       // capture at edge k+1
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid got=%0h exp=1", rsp_valid); end
      tests++; if (rsp_result !== 32'h8 || rsp_tag !== 4'h1 || rsp_zero !== 1'b0) begin fails++; $display("FAIL single_data got=%0h/%0h/%0h exp=8/1/0", rsp_result, rsp_tag, rsp_zero); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0 || occupancy !== '0) begin fails++; $display("FAIL single_drain got=%0h/%0d exp=0/0", rsp_valid, occupancy); end
      step();
   endtask

   task automatic test_wrap_zero();
      logic [N-1:0]     er [3];
      logic [TAG_W-1:0] et [3];
      logic             ez [3];
      er[0] = 32'hFFFF_FFFF; et[0] = 4'h2; ez[0] = 1'b0;
      er[1] = 32'h0;         et[1] = 4'h3; ez[1] = 1'b1;
      er[2] = 32'h0;         et[2] = 4'h4; ez[2] = 1'b1;
      rsp_ready = 1'b0;
      drive(32'h0, 32'h1, 2'b01, 4'h2);                 step();
      drive(32'hFFFF_FFFF, 32'h1, 2'b00, 4'h3);         step();
      drive(32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 4'h4); step();
      req_valid = 1'b0;
      step();
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (rsp_valid !== 1'b1 || rsp_result !== er[i] || rsp_tag !== et[i] || rsp_zero !== ez[i]) begin
            fails++;
            $display("FAIL wrap_zero_%0d got v=%0h r=%0h t=%0h z=%0h exp v=1 r=%0h t=%0h z=%0h",
                     i, rsp_valid, rsp_result, rsp_tag, rsp_zero, er[i], et[i], ez[i]);
         end
         step();
      end
      rsp_ready = 1'b0;
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wrap_zero_empty got=%0h exp=0", rsp_valid); end
      step();
   endtask

   task automatic test_backpressure();
      int acc = 0, got = 0;
      rsp_ready = 1'b0;
      for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
         if (acc < 5) drive(32'(acc) << 4, 32'(acc), 2'b00, 4'(acc));
         else req_valid = 1'b0;
         if (cyc == 7) rsp_ready = 1'b1;
         @(negedge clk);
         if (cyc == 5 || cyc == 6) begin
            tests++;
            if (req_ready !== 1'b0 || occupancy !== 3'd4 || acc != 4) begin
               fails++;
               $display("FAIL bp_full_%0d got ready=%0h occ=%0d acc=%0d exp ready=0 occ=4 acc=4", cyc, req_ready, occupancy, acc);
            end
            tests++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'h0 || rsp_result !== 32'h0) begin
               fails++;
               $display("FAIL bp_hold_head_%0d got v=%0h t=%0h r=%0h exp v=1 t=0 r=0", cyc, rsp_valid, rsp_tag, rsp_result);
            end
         end
         if (rsp_valid && rsp_ready) begin
            tests++;
            if (rsp_tag !== 4'(got) || rsp_result !== (32'(got) << 4) + 32'(got)) begin
               fails++;
               $display("FAIL bp_order_%0d got t=%0h r=%0h exp t=%0h r=%0h", got, rsp_tag, rsp_result,
                        4'(got), (32'(got) << 4) + 32'(got));
            end
            got++;
         end
         if (req_valid && req_ready) acc++;
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      tests++; if (got != 5 || acc != 5) begin fails++; $display("FAIL bp_count got rsp=%0d acc=%0d exp 5/5", got, acc); end
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0 || occupancy !== '0) begin fails++; $display("FAIL bp_drain got=%0h/%0d exp=0/0", rsp_valid, occupancy); end
      step();
   endtask

   task automatic test_streaming();
      logic [N+TAG_W-1:0] q[$];
      logic [N-1:0] a, b;
      logic [1:0]   s;
      int sent = 0, got = 0;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && got < 64; cyc++) begin
         if (sent < 64) begin
            a = $urandom; b = $urandom; s = 2'($urandom_range(0, 3));
            if (cyc % 9 == 4) begin b = a; s = 2'b01; end
            drive(a, b, s, 4'(sent));
         end else req_valid = 1'b0;
         @(negedge clk);
         if (sent < 64) begin
            tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL stream_ready_%0d got=%0h exp=1", cyc, req_ready); end
         end
         if (cyc >= 2 && cyc < 66) begin
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL stream_valid_%0d got=%0h exp=1", cyc, rsp_valid); end
         end
         if (rsp_valid) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL stream_extra_%0d got t=%0h r=%0h exp none", cyc, rsp_tag, rsp_result);
            end else begin
               tests++;
               if ({rsp_result, rsp_tag} !== q[0] || rsp_zero !== (q[0][N+TAG_W-1:TAG_W] == '0)) begin
                  fails++;
                  $display("FAIL stream_data_%0d got r=%0h t=%0h z=%0h exp r=%0h t=%0h", cyc, rsp_result, rsp_tag,
                           rsp_zero, q[0][N+TAG_W-1:TAG_W], q[0][TAG_W-1:0]);
               end
               void'(q.pop_front());
            end
            got++;
         end
         if (req_valid && req_ready) begin
            q.push_back({model(req_op_a, req_op_b, req_sel), req_tag});
            sent++;
         end
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      tests++; if (sent != 64 || got != 64) begin fails++; $display("FAIL stream_count got sent=%0d rsp=%0d exp 64/64", sent, got); end
   endtask

   task automatic test_simul_full();
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(32'(i), 32'h100, 2'b11, 4'(8 + i));
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      // three queued + one in the issue stage
      tests++; if (occupancy !== 3'd4 || req_ready !== 1'b0) begin fails++; $display("FAIL full_occ got occ=%0d ready=%0h exp 4/0", occupancy, req_ready); end
      tests++; if (rsp_tag !== 4'h8 || rsp_result !== 32'h100) begin fails++; $display("FAIL full_head0 got t=%0h r=%0h exp t=8 r=100", rsp_tag, rsp_result); end
      for (int j = 1; j < 4; j++) begin
         step();
         @(negedge clk);
         if (j == 1) begin
            // pop and capture together keep the FIFO count at three
            tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL full_pushpop_occ got=%0d exp=3", occupancy); end
         end
         tests++;
         if (rsp_valid !== 1'b1 || rsp_tag !== 4'(8 + j) || rsp_result !== (32'h100 | 32'(j))) begin
            fails++;
            $display("FAIL full_head%0d got v=%0h t=%0h r=%0h exp v=1 t=%0h r=%0h", j, rsp_valid, rsp_tag, rsp_result,
                     4'(8 + j), 32'h100 | 32'(j));
         end
      end
      step();
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0 || occupancy !== '0) begin fails++; $display("FAIL full_empty got=%0h/%0d exp=0/0", rsp_valid, occupancy); end
      tests++; if (rsp_tag !== 4'hB || rsp_result !== 32'h103) begin fails++; $display("FAIL full_hold_last got t=%0h r=%0h exp t=b r=103", rsp_tag, rsp_result); end
      rsp_ready = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive(32'(i), 32'h1, 2'b00, 4'(i));
         step();
      end
      req_valid = 1'b0;
      @(negedge clk);
      tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL rstmid_pre_occ got=%0d exp=3", occupancy); end
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready_%0d got=%0h exp=0", i, req_ready); end
         step();
      end
      rst = 1'b0;
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0 || occupancy !== '0 || req_ready !== 1'b1) begin
         fails++; $display("FAIL rstmid_after got v=%0h occ=%0d ready=%0h exp 0/0/1", rsp_valid, occupancy, req_ready);
      end
      tests++; if (rsp_result !== '0 || rsp_tag !== '0 || rsp_zero !== 1'b1) begin
         fails++; $display("FAIL rstmid_data got r=%0h t=%0h z=%0h exp 0/0/1", rsp_result, rsp_tag, rsp_zero);
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale_%0d got=%0h exp=0", i, rsp_valid); end
      end
      rsp_ready = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap_zero();
      test_backpressure();
      test_streaming();
      test_simul_full();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
